clk_wiz_rst_seq: RTL and testbench

Reset sequencer and lock supervisor that drives the clocking wizard's `reset` input and consumes its `locked` / `input_clk_stopped` status. It runs on the free-running `dac_clk` reference. It holds the wizard in reset, waits for lock, and requires lock to stay stable before releasing a system reset to downstream logic. On loss of lock it re-runs the sequence and counts the events.

---
 rtl/clk_wiz_rst_seq_if.sv | 23 ++
 rtl/clk_wiz_rst_seq.sv | 130 +++++++++++++
 tb/tb_clk_wiz_rst_seq.sv | 314 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clk_wiz_rst_seq_if.sv
// Control and status bundle between the clocking-wizard reset sequencer and the wizard and downstream logic.
// Latency: none (wires only). Backpressure: none; every signal is a level.
// master = sequencer side, slave = wizard/consumer side.
interface clk_wiz_rst_seq_if;
   logic       locked;
   logic       input_clk_stopped;
   logic       mmcm_reset;
   logic       sys_rst;
   logic       clk_ready;
   logic [7:0] lock_loss_cnt;
   logic [7:0] retry_cnt;
   logic [1:0] seq_state;

   modport master (
      input  locked, input_clk_stopped,
      output mmcm_reset, sys_rst, clk_ready, lock_loss_cnt, retry_cnt, seq_state
   );

   modport slave (
      output locked, input_clk_stopped,
      input  mmcm_reset, sys_rst, clk_ready, lock_loss_cnt, retry_cnt, seq_state
   );
endinterface

// File: rtl/clk_wiz_rst_seq.sv
// Clocking-wizard reset sequencer and lock supervisor on dac_clk; the WAIT_LOCK timeout/retry path is built only with CLK_WIZ_RST_SEQ_RETRY_EN.
// Latency: status is seen SYNC_STAGES edges after sampling; outputs decode the registered state, so there is no input-to-output path.
// Backpressure: none; locked/input_clk_stopped are level-sampled every cycle.
module clk_wiz_rst_seq #(
   parameter int RST_HOLD_CYCLES = 16,
   parameter int LOCK_TIMEOUT    = 1024,
   parameter int STABLE_CYCLES   = 64,
   parameter int SYNC_STAGES     = 2
) (
   input  logic              dac_clk,
   input  logic              reset,
   clk_wiz_rst_seq_if.master bus
);
   localparam int MAX_A   = (RST_HOLD_CYCLES > STABLE_CYCLES) ? RST_HOLD_CYCLES : STABLE_CYCLES;
   localparam int CNT_MAX = (LOCK_TIMEOUT > MAX_A) ? LOCK_TIMEOUT : MAX_A;
   localparam int CNT_W   = $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(RST_HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
   localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
`endif

   typedef enum logic [1:0] {
      RESET_HOLD = 2'd0,
      WAIT_LOCK  = 2'd1,
      STABLE     = 2'd2,
      RUN        = 2'd3
   } seq_state_t;

   logic [SYNC_STAGES-1:0] lock_sync;
   logic [SYNC_STAGES-1:0] stop_sync;
   logic                   locked_s;
   logic                   stopped_s;

   seq_state_t             state_q;
   seq_state_t             state_d;
   logic [CNT_W-1:0]       cnt_q;
   logic [7:0]             lock_loss_q;
   logic                   loss_inc;

   // Both status inputs come from the wizard's clock domain.
   always_ff @(posedge dac_clk or posedge reset) begin
      if (reset) begin
         lock_sync <= '0;
         stop_sync <= '0;
      end else begin
         lock_sync <= {lock_sync[SYNC_STAGES-2:0], bus.locked};
         stop_sync <= {stop_sync[SYNC_STAGES-2:0], bus.input_clk_stopped};
      end
   end

   assign locked_s  = lock_sync[SYNC_STAGES-1];
   assign stopped_s = stop_sync[SYNC_STAGES-1];

`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
   logic       retry_inc;
   logic [7:0] retry_q;
`endif

   always_comb begin
      state_d  = state_q;
      loss_inc = 1'b0;
`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
      retry_inc = 1'b0;
`endif
      case (state_q)
         RESET_HOLD: begin
            if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            if (locked_s) begin
               state_d = STABLE;
            end
`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
            else if (cnt_q == TIMEOUT_LAST) begin
               state_d   = RESET_HOLD;
               retry_inc = 1'b1;
            end
`endif
         end
         STABLE: begin
            if (!locked_s)                 state_d = WAIT_LOCK;
            else if (stopped_s)            state_d = RESET_HOLD;
            else if (cnt_q == STABLE_LAST) state_d = RUN;
         end
         RUN: begin
            if (!locked_s || stopped_s) begin
               state_d  = RESET_HOLD;
               loss_inc = 1'b1;
            end
         end
         default: state_d = RESET_HOLD;
      endcase
   end

   // One shared cycle counter; it restarts on every state change and
   // parks at all-ones during an unbounded lock wait instead of wrapping.
   always_ff @(posedge dac_clk or posedge reset) begin
      if (reset) begin
         state_q <= RESET_HOLD;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_d != state_q)  cnt_q <= '0;
         else if (cnt_q != '1)    cnt_q <= cnt_q + 1'b1;
      end
   end

   always_ff @(posedge dac_clk or posedge reset) begin
      if (reset)                                lock_loss_q <= '0;
      else if (loss_inc && lock_loss_q != 8'hFF) lock_loss_q <= lock_loss_q + 8'd1;
   end

`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
   always_ff @(posedge dac_clk or posedge reset) begin
      if (reset)                             retry_q <= '0;
      else if (retry_inc && retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
   end
   assign bus.retry_cnt = retry_q;
`else
   assign bus.retry_cnt = '0;
`endif

   assign bus.mmcm_reset    = (state_q == RESET_HOLD);
   assign bus.sys_rst       = (state_q != RUN);
   assign bus.clk_ready     = (state_q == RUN);
   assign bus.seq_state     = state_q;
   assign bus.lock_loss_cnt = lock_loss_q;
endmodule

// File: tb/tb_clk_wiz_rst_seq.sv
// Bench for clk_wiz_rst_seq: vector table, hand-built corner sequences and a randomized run against a reference model.
// Edges are counted from the edge that first samples a changed input (that edge is number 1).
module tb_clk_wiz_rst_seq;
   localparam int HOLD = 16;
   localparam int TO   = 1024;
   localparam int STAB = 64;
   localparam int SYNC = 2;

   logic dac_clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   clk_wiz_rst_seq_if bus ();

   clk_wiz_rst_seq #(
      .RST_HOLD_CYCLES (HOLD),
      .LOCK_TIMEOUT    (TO),
      .STABLE_CYCLES   (STAB),
      .SYNC_STAGES     (SYNC)
   ) dut (
      .dac_clk (dac_clk),
      .reset   (reset),
      .bus     (bus)
   );

   always #5 dac_clk = ~dac_clk;

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation did not finish (act=running exp=done)");
      $fatal(1, "watchdog");
   end

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
      end
   endtask

   function automatic int sig(input int which);
      case (which)
         0:       return int'(bus.mmcm_reset);
         1:       return int'(bus.sys_rst);
         2:       return int'(bus.seq_state);
         default: return int'(bus.clk_ready);
      endcase
   endfunction

   // n = edges until the selected signal equals val, or -1 when the budget runs out.
   task automatic wait_for(input int which, input int val, input int budget, output int n);
      n = -1;
      for (int e = 1; e <= budget; e++) begin
         @(negedge dac_clk);
         if (sig(e == 0 ? which : which) == val) begin
            n = e;
            break;
         end
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge dac_clk);
   endtask

   // Reference model: synchronizers as an SYNC-deep delay line, phases with elapsed-time rules.
   int m_ph, m_t, m_loss, m_retry;
   bit m_lq[$];
   bit m_sq[$];
   bit m_on = 1'b0;

   function automatic void m_reset();
      m_ph = 0; m_t = 0; m_loss = 0; m_retry = 0;
      m_lq.delete(); m_sq.delete();
      for (int i = 0; i < SYNC; i++) begin
         m_lq.push_back(1'b0);
         m_sq.push_back(1'b0);
      end
   endfunction

   function automatic void m_step(input bit lk, input bit st);
      bit ls, ss;
      int nph;
      ls = m_lq.pop_front(); m_lq.push_back(lk);
      ss = m_sq.pop_front(); m_sq.push_back(st);
      nph = m_ph;
      case (m_ph)
         0: if (m_t == HOLD - 1) nph = 1;
         1: begin
            if (ls) nph = 2;
`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
            else if (m_t == TO - 1) begin
               nph = 0;
               if (m_retry < 255) m_retry++;
            end
`endif
         end
         2: begin
            if (!ls)                 nph = 1;
            else if (ss)             nph = 0;
            else if (m_t == STAB - 1) nph = 3;
         end
         default: begin
            if (!ls || ss) begin
               nph = 0;
               if (m_loss < 255) m_loss++;
            end
         end
      endcase
      m_t  = (nph != m_ph) ? 0 : m_t + 1;
      m_ph = nph;
   endfunction

   always @(posedge dac_clk or posedge reset) begin
      if (reset)     m_reset();
      else if (m_on) m_step(bus.locked, bus.input_clk_stopped);
   end

   task automatic cmp_model();
      check("rnd_state",  int'(bus.seq_state),     m_ph);
      check("rnd_mmcm",   int'(bus.mmcm_reset),    int'(m_ph == 0));
      check("rnd_sysrst", int'(bus.sys_rst),       int'(m_ph != 3));
      check("rnd_ready",  int'(bus.clk_ready),     int'(m_ph == 3));
      check("rnd_loss",   int'(bus.lock_loss_cnt), m_loss);
      check("rnd_retry",  int'(bus.retry_cnt),     m_retry);
   endtask

   typedef struct {
      bit lk;
      bit st;
      int n;
      int state;
      int srst;
      int mrst;
      int loss;
   } vec_t;

   vec_t vecs[15];

   initial begin
      int n, rise, mm, wl, wl_loss, fall, hold;
      bit lk, st;

      vecs[0]  = '{0, 0, 10, 0, 1, 1, 0};
      vecs[1]  = '{0, 0, 6,  1, 1, 0, 0};
      vecs[2]  = '{1, 0, 2,  1, 1, 0, 0};
      vecs[3]  = '{1, 0, 1,  2, 1, 0, 0};
      vecs[4]  = '{1, 0, 64, 3, 0, 0, 0};
      vecs[5]  = '{1, 0, 20, 3, 0, 0, 0};
      vecs[6]  = '{0, 0, 2,  3, 0, 0, 0};
      vecs[7]  = '{0, 0, 1,  0, 1, 1, 1};
      vecs[8]  = '{0, 0, 15, 0, 1, 1, 1};
      vecs[9]  = '{0, 0, 1,  1, 1, 0, 1};
      vecs[10] = '{1, 1, 3,  2, 1, 0, 1};
      vecs[11] = '{1, 1, 1,  0, 1, 1, 1};
      vecs[12] = '{1, 0, 16, 1, 1, 0, 1};
      vecs[13] = '{1, 0, 1,  2, 1, 0, 1};
      vecs[14] = '{0, 1, 3,  1, 1, 0, 1};

      reset = 1'b1;
      bus.locked = 1'b0;
      bus.input_clk_stopped = 1'b0;
      #2;
      check("rst_state", int'(bus.seq_state), 0);
      check("rst_mmcm",  int'(bus.mmcm_reset), 1);
      check("rst_sysrst", int'(bus.sys_rst), 1);
      check("rst_ready", int'(bus.clk_ready), 0);
      check("rst_loss",  int'(bus.lock_loss_cnt), 0);
      check("rst_retry", int'(bus.retry_cnt), 0);

      // Reset release with locked low.
      @(negedge dac_clk); reset = 1'b0;
      wait_for(0, 0, 100, n);
      check("hold_edges", n, HOLD);
`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
      wait_for(0, 1, 2000, n);
      check("timeout_edges", n, TO);
      check("timeout_retry", int'(bus.retry_cnt), 1);
      check("timeout_sysrst", int'(bus.sys_rst), 1);
      wait_for(0, 0, 100, n);
      check("rehold_edges", n, HOLD);
`endif

      // Lock arrives 30 cycles into WAIT_LOCK.
      cycles(30);
      bus.locked = 1'b1;
      wait_for(1, 0, 200, n);
      check("lock_release_edge", n, SYNC + STAB + 1);
      check("run_ready", int'(bus.clk_ready), 1);
      check("run_state", int'(bus.seq_state), 3);
      check("run_loss0", int'(bus.lock_loss_cnt), 0);

      // 5-cycle lock dropout in RUN.
      cycles(5);
      bus.locked = 1'b0;
      rise = -1; mm = -1;
      for (int e = 1; e <= 5; e++) begin
         @(negedge dac_clk);
         if (bus.sys_rst && rise < 0)    rise = e;
         if (bus.mmcm_reset && mm < 0)   mm = e;
      end
      bus.locked = 1'b1;
      check("loss_sysrst_edge", rise, SYNC + 1);
      check("loss_mmcm_edge", mm, SYNC + 1);
      check("loss_cnt1", int'(bus.lock_loss_cnt), 1);
      wait_for(0, 0, 100, n);
      check("loss_hold_end", (n < 0) ? -1 : n + 5, SYNC + 1 + HOLD);
      wait_for(1, 0, 200, n);
      check("relock_run", int'(n >= 0), 1);

      // Lock drop at stable count 40, then a full window again.
      bus.locked = 1'b0; @(negedge dac_clk); bus.locked = 1'b1;
      wait_for(2, 2, 100, n);
      check("enter_stable", int'(n >= 0), 1);
      cycles(38);
      bus.locked = 1'b0; @(negedge dac_clk); bus.locked = 1'b1;
      wl = -1; wl_loss = -1; fall = -1;
      for (int r = 1; r <= 100; r++) begin
         @(negedge dac_clk);
         if (wl < 0 && bus.seq_state == 2'd1) begin
            wl = r;
            wl_loss = int'(bus.lock_loss_cnt);
         end
         if (!bus.sys_rst) begin
            fall = r;
            break;
         end
      end
      check("stable_drop_wait", wl, SYNC);
      check("stable_drop_loss", wl_loss, 2);
      check("stable_rewindow", fall, SYNC + STAB + 1);

      // input_clk_stopped in RUN, then drive lock_loss_cnt into saturation.
      bus.input_clk_stopped = 1'b1; @(negedge dac_clk); bus.input_clk_stopped = 1'b0;
      wait_for(1, 1, 10, n);
      check("stop_sysrst_edge", (n < 0) ? -1 : n + 1, SYNC + 1);
      check("stop_loss", int'(bus.lock_loss_cnt), 3);
      for (int i = 0; i < 300; i++) begin
         wait_for(2, 3, 400, n);
         check("sat_reach_run", int'(n >= 0), 1);
         if (n < 0) break;
         bus.input_clk_stopped = 1'b1; @(negedge dac_clk); bus.input_clk_stopped = 1'b0;
         wait_for(2, 0, 10, n);
         if (n < 0) break;
      end
      check("loss_saturated", int'(bus.lock_loss_cnt), 255);

      // Async reset pulse mid-STABLE, then a long wait with locked low.
      wait_for(2, 3, 400, n);
      bus.locked = 1'b0; @(negedge dac_clk); bus.locked = 1'b1;
      wait_for(2, 2, 100, n);
      check("pre_areset_stable", int'(n >= 0), 1);
      cycles(10);
      #2 reset = 1'b1;
      #1;
      check("areset_state", int'(bus.seq_state), 0);
      check("areset_mmcm", int'(bus.mmcm_reset), 1);
      check("areset_sysrst", int'(bus.sys_rst), 1);
      check("areset_ready", int'(bus.clk_ready), 0);
      check("areset_loss", int'(bus.lock_loss_cnt), 0);
      check("areset_retry", int'(bus.retry_cnt), 0);
      @(negedge dac_clk); reset = 1'b0; bus.locked = 1'b0;
      cycles(5000);
      check("longwait_state", int'(bus.seq_state), 1);
      check("longwait_mmcm", int'(bus.mmcm_reset), 0);
`ifdef CLK_WIZ_RST_SEQ_RETRY_EN
      check("longwait_retry", int'(bus.retry_cnt), 5000 / (HOLD + TO));
`else
      check("longwait_retry", int'(bus.retry_cnt), 0);
`endif

      // Vector table from a fresh reset.
      reset = 1'b1; @(negedge dac_clk); reset = 1'b0;
      foreach (vecs[i]) begin
         bus.locked = vecs[i].lk;
         bus.input_clk_stopped = vecs[i].st;
         cycles(vecs[i].n);
         check($sformatf("vec%0d_state", i), int'(bus.seq_state), vecs[i].state);
         check($sformatf("vec%0d_sysrst", i), int'(bus.sys_rst), vecs[i].srst);
         check($sformatf("vec%0d_mmcm", i), int'(bus.mmcm_reset), vecs[i].mrst);
         check($sformatf("vec%0d_ready", i), int'(bus.clk_ready), int'(vecs[i].state == 3));
         check($sformatf("vec%0d_loss", i), int'(bus.lock_loss_cnt), vecs[i].loss);
      end

      // Randomized run against the reference model.
      bus.locked = 1'b0; bus.input_clk_stopped = 1'b0;
      reset = 1'b1;
      #1 m_on = 1'b1;
      hold = 0; lk = 1'b0;
      for (int c = 0; c < 6000; c++) begin
         @(negedge dac_clk);
         cmp_model();
         if (reset) begin
            reset = 1'b0;
         end else if ($urandom_range(999) == 0) begin
            reset = 1'b1;
            #1 cmp_model();
         end
         if (hold == 0) begin
            lk   = ($urandom_range(99) < 75);
            hold = $urandom_range(1, 120);
         end
         hold--;
         st = ($urandom_range(199) == 0);
         bus.locked = lk;
         bus.input_clk_stopped = st;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
